// File: rtl/rn_pkg.sv
// Shared constants and FSM state encoding for the Rn RAM reader.
// Included by every rn_ram_reader design file through import rn_pkg::*.
package rn_pkg;

  localparam int RN_ADDR_W = 9;
  localparam int RN_DATA_W = 32;
  localparam int RN_DEPTH  = 512;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } rn_state_e;

  // Width of a counter that must hold values 0..lat-1 (never narrower than 1 bit).
  function automatic int rn_cnt_width(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/rn_ram_reader_if.sv
// Bus bundle for rn_ram_reader: burst command, RAM port and downstream word stream.
// The checksum signal exists only when RN_READ_CHECKSUM_EN is defined.
interface rn_ram_reader_if
  import rn_pkg::*;
#(
  parameter int ADDR_W = RN_ADDR_W,
  parameter int DATA_W = RN_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

`ifdef RN_READ_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport slave (
    input  start, base_addr, count, ram_q, out_ready,
    output busy, done, ram_addr, ram_wren, out_data, out_valid, checksum
  );

  modport master (
    output start, base_addr, count, ram_q, out_ready,
    input  busy, done, ram_addr, ram_wren, out_data, out_valid, checksum
  );
`else
  modport slave (
    input  start, base_addr, count, ram_q, out_ready,
    output busy, done, ram_addr, ram_wren, out_data, out_valid
  );

  modport master (
    output start, base_addr, count, ram_q, out_ready,
    input  busy, done, ram_addr, ram_wren, out_data, out_valid
  );
`endif

endinterface

// File: rtl/rn_lat_counter.sv
// Load/decrement down-counter with zero flag, used to time the RAM read latency.
module rn_lat_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Decrement saturates at zero so a stray dec can never wrap around.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rn_ram_reader.sv
// Burst reader for the Rn autocorrelation RAM: one outstanding read at a time, words
// handed downstream over valid/ready. Optional feature macro: RN_READ_CHECKSUM_EN.
module rn_ram_reader
  import rn_pkg::*;
#(
  parameter int ADDR_W   = RN_ADDR_W,
  parameter int DATA_W   = RN_DATA_W,
  parameter int READ_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  rn_ram_reader_if.slave bus
);

  localparam int CNT_W = rn_cnt_width(READ_LAT);

  rn_state_e         state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   index_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic              handshake;
  logic              cnt_zero;
  logic [ADDR_W:0]   index_inc;

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign handshake = (state_q == ST_PRESENT) && bus.out_ready;
  assign index_inc = index_q + (ADDR_W+1)'(1);

  rn_lat_counter #(
    .WIDTH (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == ST_ISSUE),
    .load_val_i (CNT_W'(READ_LAT - 1)),
    .dec_i      (state_q == ST_WAIT),
    .zero_o     (cnt_zero)
  );

  // Address wraps naturally through the ADDR_W-bit truncation of base + index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      index_q     <= '0;
      ram_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            base_q  <= bus.base_addr;
            count_q <= bus.count;
            index_q <= '0;
            busy_q  <= 1'b1;
            state_q <= (bus.count == '0) ? ST_FINISH : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ram_addr_q <= base_q + index_q[ADDR_W-1:0];
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            out_data_q  <= bus.ram_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            index_q     <= index_inc;
            state_q     <= (index_inc == count_q) ? ST_FINISH : ST_ISSUE;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef RN_READ_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Running sum of accepted words; holds its value after the burst until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (handshake) begin
      checksum_q <= checksum_q + out_data_q;
    end
  end

  assign bus.checksum = checksum_q;
`endif

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wren  = 1'b0;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rn_ram_reader.sv
// Scoreboard bench for rn_ram_reader: expected words are queued at start, a monitor
// pops and compares on every handshake and done pulse.
module tb_rn_ram_reader;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 2;
  localparam int DEPTH    = 512;

  logic clk;
  logic rst;

  rn_ram_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rn_ram_reader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data appears READ_LAT-1 registered stages after the address changes.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addrPipe;
  always @(posedge clk) addrPipe <= bus.ram_addr;
  assign bus.ram_q = mem[addrPipe];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int hsCount = 0;
  int lastEv = 0;
  int readyMode = 0;
  int stallCnt = 0;

  logic [DATA_W-1:0] expWordQ[$];
  logic [ADDR_W-1:0] expAddrQ[$];
  logic [DATA_W-1:0] expDoneQ[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got event, expected none/other (t=%0t)", name, $time);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) failNow("idleTimeout");
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] sum;
    waitIdle();
    @(posedge clk) #1;
    bus.start = 1'b1;
    bus.base_addr = b;
    bus.count = c;
    sum = '0;
    for (int i = 0; i < int'(c); i++) begin
      a = b + ADDR_W'(i);
      expAddrQ.push_back(a);
      expWordQ.push_back(mem[a]);
      sum = sum + mem[a];
    end
    expDoneQ.push_back(sum);
    @(posedge clk) #1;
    bus.start = 1'b0;
    bus.base_addr = ADDR_W'($urandom);
    bus.count = (ADDR_W+1)'($urandom);
  endtask

  // Downstream ready generator: always ready, random, or a 5-cycle stall on the next word.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk) #1;
      case (readyMode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.out_valid && stallCnt < 5) begin
            bus.out_ready = 1'b0;
            stallCnt++;
          end else if (bus.out_valid) begin
            bus.out_ready = 1'b1;
            readyMode = 0;
          end else begin
            bus.out_ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    logic              prevStall;
    logic [DATA_W-1:0] prevData;
    logic [ADDR_W-1:0] prevAddr;
    prevStall = 1'b0;
    prevData = '0;
    prevAddr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prevStall = 1'b0;
      end else begin
        if (bus.start && !bus.busy) lastEv = cyc;
        checkOutput("validOnlyWhenBusy", 32'(bus.out_valid & ~bus.busy), 0);
        if (prevStall) begin
          checkOutput("stallValid", 32'(bus.out_valid), 1);
          checkOutput("stallData", bus.out_data, prevData);
          checkOutput("stallAddr", 32'(bus.ram_addr), 32'(prevAddr));
        end
        prevStall = bus.out_valid && !bus.out_ready;
        prevData = bus.out_data;
        prevAddr = bus.ram_addr;
        if (bus.out_valid && bus.out_ready) begin
          hsCount++;
          lastEv = cyc;
          if (expWordQ.size() == 0) begin
            failNow("unexpectedWord");
          end else begin
            checkOutput("outData", bus.out_data, expWordQ.pop_front());
            checkOutput("ramAddr", 32'(bus.ram_addr), 32'(expAddrQ.pop_front()));
            checkOutput("ramWren", 32'(bus.ram_wren), 0);
          end
        end
        if (bus.done) begin
          checkOutput("doneTiming", cyc - lastEv, 2);
          if (expDoneQ.size() == 0) begin
            failNow("unexpectedDone");
          end else begin
            checkOutput("wordsLeftAtDone", expWordQ.size(), 0);
`ifdef RN_READ_CHECKSUM_EN
            checkOutput("checksum", bus.checksum, expDoneQ.pop_front());
`else
            void'(expDoneQ.pop_front());
`endif
          end
        end
      end
    end
  end

  task automatic checkResetState();
    checkOutput("rstRamAddr", 32'(bus.ram_addr), 0);
    checkOutput("rstOutData", bus.out_data, 0);
    checkOutput("rstOutValid", 32'(bus.out_valid), 0);
    checkOutput("rstBusy", 32'(bus.busy), 0);
    checkOutput("rstDone", 32'(bus.done), 0);
    checkOutput("rstWren", 32'(bus.ram_wren), 0);
  endtask

  initial begin
    int target;
    int n;
    logic [ADDR_W-1:0] addrBefore;
    for (int k = 0; k < DEPTH; k++) mem[k] = DATA_W'(k * 3);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    rst = 1'b1;

    readyMode = 0;
    applyStimulus(9'd0, 10'd4);
    applyStimulus(9'd510, 10'd4);
    applyStimulus(9'd511, 10'd3);

    waitIdle();
    stallCnt = 0;
    readyMode = 2;
    applyStimulus(9'd0, 10'd2);
    waitIdle();

    readyMode = 0;
    @(posedge clk) #1;
    addrBefore = bus.ram_addr;
    applyStimulus(9'd7, 10'd0);
    waitIdle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("zeroCountAddr", 32'(bus.ram_addr), 32'(addrBefore));

    applyStimulus(9'd20, 10'd3);
    @(posedge clk) #1;
    bus.start = 1'b1;
    bus.base_addr = 9'd100;
    bus.count = 10'd7;
    @(posedge clk) #1;
    bus.start = 1'b0;
    waitIdle();

    // Reset in the WAIT phase of the second word of a four-word burst.
    target = hsCount + 1;
    applyStimulus(9'd0, 10'd4);
    n = 0;
    while (hsCount < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) failNow("firstWordTimeout");
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst = 1'b0;
    #1;
    checkResetState();
    expWordQ.delete();
    expAddrQ.delete();
    expDoneQ.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    applyStimulus(9'd5, 10'd1);
    waitIdle();

    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    for (int t = 0; t < 25; t++) begin
      waitIdle();
      readyMode = int'($urandom_range(0, 1));
      if (t % 5 == 4)
        applyStimulus(ADDR_W'($urandom_range(500, 511)), (ADDR_W+1)'($urandom_range(10, 20)));
      else
        applyStimulus(ADDR_W'($urandom), (ADDR_W+1)'($urandom_range(0, 8)));
    end
    waitIdle();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("wordsLeftAtEnd", expWordQ.size(), 0);
    checkOutput("donesLeftAtEnd", expDoneQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
